// File: rtl/pipelined_cla_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-look-ahead adder.
package cla_pkg;

  typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;

  function automatic bit cla_width_ok(int unsigned width, int unsigned group);
    return (group != 0) && (width >= 4) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
);
  import cla_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  mode_e            mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_cla_adder_group.sv
// Combinational GROUP-bit look-ahead slice; also exposes the carry into its MSB.
module cla_group #(
  parameter int unsigned GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s = p ^ c[GROUP-1:0];
  end

  assign cout  = c[GROUP];
  assign c_msb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit add/subtract: one GROUP-bit look-ahead slice and register per stage,
// valid/ready handshake with a single global stall.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);

  localparam int unsigned NUM_GROUPS = WIDTH / GROUP;
  localparam int unsigned LAST       = NUM_GROUPS - 1;

  if (!cla_width_ok(WIDTH, GROUP)) begin : g_width_check
    $error("pipelined_cla_adder: WIDTH must be >= 4 and a multiple of GROUP");
  end

  // as_q holds finished sum bits below the current slice and untouched A bits above it.
  logic [WIDTH-1:0] as_q [NUM_GROUPS];
  logic [WIDTH-1:0] as_d [NUM_GROUPS];
  logic [WIDTH-1:0] b_q  [NUM_GROUPS];
  logic [WIDTH-1:0] b_d  [NUM_GROUPS];
  logic             c_q  [NUM_GROUPS];
  logic             c_d  [NUM_GROUPS];
  logic             v_q  [NUM_GROUPS];
  logic             v_d  [NUM_GROUPS];
  logic             ovf_q;
  logic             ovf_d;

  logic [WIDTH-1:0] stg_as [NUM_GROUPS];
  logic [WIDTH-1:0] stg_b  [NUM_GROUPS];
  logic             stg_c  [NUM_GROUPS];
  logic             stg_v  [NUM_GROUPS];

  logic [GROUP-1:0] grp_s  [NUM_GROUPS];
  logic             grp_co [NUM_GROUPS];
  logic             grp_cm [NUM_GROUPS];

  logic stall;

  assign stall         = v_q[LAST] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = as_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;

  always_comb begin : stage_inputs
    stg_as[0] = bus.a;
    stg_b[0]  = (bus.mode == SUB) ? ~bus.b : bus.b;
    stg_c[0]  = (bus.mode == SUB) ? 1'b1 : bus.cin;
    stg_v[0]  = bus.in_valid;
    for (int unsigned k = 1; k < NUM_GROUPS; k++) begin
      stg_as[k] = as_q[k-1];
      stg_b[k]  = b_q[k-1];
      stg_c[k]  = c_q[k-1];
      stg_v[k]  = v_q[k-1];
    end
  end

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_slice
    cla_group #(
      .GROUP(GROUP)
    ) u_group (
      .a    (stg_as[k][k*GROUP +: GROUP]),
      .b    (stg_b[k][k*GROUP +: GROUP]),
      .cin  (stg_c[k]),
      .s    (grp_s[k]),
      .cout (grp_co[k]),
      .c_msb(grp_cm[k])
    );
  end

  always_comb begin : next_state
    for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
      as_d[k]                    = stg_as[k];
      as_d[k][k*GROUP +: GROUP]  = grp_s[k];
      b_d[k]                     = stg_b[k];
      c_d[k]                     = grp_co[k];
      v_d[k]                     = stg_v[k];
    end
    ovf_d = grp_cm[LAST] ^ grp_co[LAST];
    // Bubbles still shift; only a blocked output freezes the whole pipe.
    if (stall) begin
      as_d  = as_q;
      b_d   = b_q;
      c_d   = c_q;
      v_d   = v_q;
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
        as_q[k] <= '0;
        b_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        v_q[k]  <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else begin
      as_q  <= as_d;
      b_q   <= b_d;
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised and directed bench for pipelined_cla_adder against an arithmetic reference model.
module tb_pipelined_cla_adder;
  import cla_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(16)) bus  ();
  pipelined_cla_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  pipelined_cla_adder #(.WIDTH(8), .GROUP(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  int checks   = 0;
  int failures = 0;
  int rx_count = 0;

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  function automatic res_t ref_model(logic [15:0] a, logic [15:0] b, logic cin, mode_e m);
    res_t        r;
    int unsigned ua   = a;
    int unsigned ub   = b;
    int          sa   = $signed(a);
    int          sb   = $signed(b);
    int unsigned full;
    int          sres;
    if (m == ADD) begin
      full   = ua + ub + cin;
      r.sum  = full[15:0];
      r.cout = full[16];
      sres   = sa + sb + int'(cin);
    end else begin
      r.sum  = a - b;
      r.cout = (ua >= ub);
      sres   = sa - sb;
    end
    r.ovf = (sres > 32767) || (sres < -32768);
    return r;
  endfunction

  res_t        expq [$];
  res_t        exp_r;
  logic        stalled_prev = 1'b0;
  logic [15:0] sum_prev;
  logic        cout_prev;
  logic        ovf_prev;

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      stalled_prev = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (stalled_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_sum", bus.sum, sum_prev);
        check("hold_cout", bus.cout, cout_prev);
        check("hold_ovf", bus.ovf, ovf_prev);
      end
      if (bus.out_valid && bus.out_ready) begin
        rx_count++;
        if (expq.size() == 0) begin
          check("unexpected_out", bus.out_valid, 0);
        end else begin
          exp_r = expq.pop_front();
          check("model_sum", bus.sum, exp_r.sum);
          check("model_cout", bus.cout, exp_r.cout);
          check("model_ovf", bus.ovf, exp_r.ovf);
        end
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      sum_prev     = bus.sum;
      cout_prev    = bus.cout;
      ovf_prev     = bus.ovf;
      if (bus.in_valid && bus.in_ready)
        expq.push_back(ref_model(bus.a, bus.b, bus.cin, bus.mode));
    end
  end

  task automatic run_directed(string tag, logic [15:0] a, logic [15:0] b, logic cin, mode_e m,
                              logic [15:0] exp_sum, logic exp_cout, logic exp_ovf);
    int n;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, bus.sum, exp_sum);
    check({tag, "_cout"}, bus.cout, exp_cout);
    check({tag, "_ovf"}, bus.ovf, exp_ovf);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  cyc;
    int  rx_before;
    int  seen;
    bit  acc;
    bit  need_new;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.mode      = ADD;
    bus.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.a         = '0;
    bus8.b         = '0;
    bus8.cin       = 1'b0;
    bus8.mode      = ADD;
    bus8.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst8_out_valid", bus8.out_valid, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    run_directed("add_ovf",   16'h7FFF, 16'h0001, 1'b0, ADD, 16'h8000, 1'b0, 1'b1);
    run_directed("add_wrap",  16'hFFFF, 16'h0001, 1'b0, ADD, 16'h0000, 1'b1, 1'b0);
    run_directed("sub_borrow",16'h0005, 16'h0007, 1'b1, SUB, 16'hFFFE, 1'b0, 1'b0);
    run_directed("sub_ovf",   16'h8000, 16'h0001, 1'b0, SUB, 16'h7FFF, 1'b1, 1'b1);
    run_directed("add_cin",   16'hFFFF, 16'hFFFF, 1'b1, ADD, 16'hFFFF, 1'b1, 1'b0);

    // Streaming with a 3-cycle output stall in the middle.
    rx_before = rx_count;
    sent      = 0;
    cyc       = 0;
    need_new  = 1'b1;
    while (sent < 8 && cyc < 100) begin
      bus.out_ready = !(cyc >= 4 && cyc < 7);
      if (need_new) begin
        bus.a    = 16'($urandom);
        bus.b    = 16'($urandom);
        bus.cin  = 1'($urandom_range(0, 1));
        bus.mode = mode_e'(1'($urandom_range(0, 1)));
      end
      bus.in_valid = 1'b1;
      #1;
      acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      need_new = acc;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc = 0;
    while (expq.size() != 0 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_sent", sent, 8);
    check("stream_drain", expq.size(), 0);
    check("stream_count", rx_count - rx_before, 8);

    // Reset while one result is held and three more are in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.a        = 16'h1234 + 16'(i);
      bus.b        = 16'h1111;
      bus.cin      = 1'b0;
      bus.mode     = ADD;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("pre_rst_held", bus.out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_sum", bus.sum, 0);
    check("midrst_cout", bus.cout, 0);
    check("midrst_ovf", bus.ovf, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("rst_no_ghost", seen, 0);
    run_directed("post_rst", 16'h00A5, 16'h0F0F, 1'b1, ADD, 16'h0FB5, 1'b0, 1'b0);

    // Single-slice configuration: one stage of latency.
    bus8.a        = 8'hFF;
    bus8.b        = 8'hFF;
    bus8.cin      = 1'b1;
    bus8.mode     = ADD;
    bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    check("s8_valid", bus8.out_valid, 1);
    check("s8_sum", bus8.sum, 8'hFF);
    check("s8_cout", bus8.cout, 1);
    check("s8_ovf", bus8.ovf, 0);
    @(posedge clk); #1;
    check("s8_single", bus8.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
